// File: rtl/csr_access_ctrl_pkg.sv
// ============================================================================
// Module      : csr_pkg
// Description : Shared constants and types for the CSR access controller:
//               CSR addresses, SYSTEM funct3 encodings, ECALL/MRET immediates,
//               mstatus bit positions and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_pkg;

   // Machine-mode CSR addresses handled by this controller
   localparam logic [11:0] c_ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] c_ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] c_ADDR_MEPC      = 12'h341;
   localparam logic [11:0] c_ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] c_ADDR_MVENDORID = 12'hF11;
   localparam logic [11:0] c_ADDR_MARCHID   = 12'hF12;

   // SYSTEM-class funct3 encodings
   localparam logic [2:0] c_F3_PRIV   = 3'b000;
   localparam logic [2:0] c_F3_CSRRW  = 3'b001;
   localparam logic [2:0] c_F3_CSRRS  = 3'b010;
   localparam logic [2:0] c_F3_CSRRC  = 3'b011;
   localparam logic [2:0] c_F3_CSRRWI = 3'b101;
   localparam logic [2:0] c_F3_CSRRSI = 3'b110;
   localparam logic [2:0] c_F3_CSRRCI = 3'b111;

   // imm[31:20] values selecting the privileged ops when funct3 = 000
   localparam logic [11:0] c_IMM_ECALL = 12'h000;
   localparam logic [11:0] c_IMM_MRET  = 12'h302;

   // mstatus bit positions
   localparam int c_MSTATUS_MIE    = 3;
   localparam int c_MSTATUS_MPIE   = 7;
   localparam int c_MSTATUS_MPP_LO = 11;
   localparam int c_MSTATUS_MPP_HI = 12;

   // Controller state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Address bits [11:10] = 2'b11 mark a read-only CSR
   function automatic logic csr_is_readonly(input logic [11:0] addr);
      return (addr[11:10] == 2'b11);
   endfunction

endpackage

`default_nettype wire

// File: rtl/csr_access_ctrl_if.sv
// ============================================================================
// Module      : csr_access_ctrl_if
// Description : Request/response channel between the EXU (master) and the
//               CSR access controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_access_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [11:0] req_csr;
   logic [31:0] req_src;
   logic [4:0]  req_zimm;
   logic        req_src_zero;
   logic [31:0] req_pc;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_redirect;
   logic [31:0] resp_npc;
   logic        resp_illegal;

   modport master (
      output req_valid, req_funct3, req_csr, req_src, req_zimm, req_src_zero, req_pc,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_redirect, resp_npc, resp_illegal,
      output resp_ready
   );

   modport slave (
      input  req_valid, req_funct3, req_csr, req_src, req_zimm, req_src_zero, req_pc,
      output req_ready,
      output resp_valid, resp_rdata, resp_redirect, resp_npc, resp_illegal,
      input  resp_ready
   );

endinterface

`default_nettype wire

// File: rtl/csr_access_ctrl_alu.sv
// ============================================================================
// Module      : csr_alu
// Description : Combinational CSR read-modify-write: new value from funct3,
//               the old CSR value and the source operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_alu
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_old,
   input  logic [XLEN-1:0] i_src,
   output logic [XLEN-1:0] o_new
);

   // Register and immediate forms share the same operation
   always_comb begin
      o_new = i_old;
      case (i_funct3)
         c_F3_CSRRW, c_F3_CSRRWI: o_new = i_src;
         c_F3_CSRRS, c_F3_CSRRSI: o_new = i_old | i_src;
         c_F3_CSRRC, c_F3_CSRRCI: o_new = i_old & ~i_src;
         default:                 o_new = i_old;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/csr_access_ctrl.sv
// ============================================================================
// Module      : csr_access_ctrl
// Description : Initiator side of the machine-mode CSR file. Executes one
//               CSRRW/CSRRS/CSRRC/ECALL/MRET at a time: IDLE accepts, EXEC
//               pulses the write strobes, RESP holds the registered response.
//               Build macro CSR_IMM_OPS_EN enables CSRRWI/CSRRSI/CSRRCI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_access_ctrl
   import csr_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
   input  logic            clk,
   input  logic            rst,
   csr_access_ctrl_if.slave bus,
   input  logic [XLEN-1:0] dout_mstatus,
   input  logic [XLEN-1:0] dout_mtvec,
   input  logic [XLEN-1:0] dout_mepc,
   input  logic [XLEN-1:0] dout_mcause,
   input  logic [XLEN-1:0] dout_mvendorid,
   input  logic [XLEN-1:0] dout_marchid,
   output logic [XLEN-1:0] din_mstatus,
   output logic [XLEN-1:0] din_mtvec,
   output logic [XLEN-1:0] din_mepc,
   output logic [XLEN-1:0] din_mcause,
   output logic            wen_mstatus,
   output logic            wen_mtvec,
   output logic            wen_mepc,
   output logic            wen_mcause
);

   state_t          r_state, w_state_next;
   logic [2:0]      r_funct3;
   logic [11:0]     r_csr;
   logic [XLEN-1:0] r_src, r_pc;
   logic [4:0]      r_zimm;
   logic            r_src_zero;

   logic [XLEN-1:0] r_resp_rdata, r_resp_npc;
   logic            r_resp_redirect, r_resp_illegal;

   logic [XLEN-1:0] w_src, w_old, w_alu_new;
   logic            w_is_csr_op, w_is_ecall, w_is_mret, w_addr_ok, w_do_write, w_illegal;
   logic            w_wen_ms, w_wen_tv, w_wen_ep, w_wen_mc, w_exec;
   logic [XLEN-1:0] w_din_ms, w_din_tv, w_din_ep, w_din_mc;

`ifndef CSR_IMM_OPS_EN
   logic w_unused_zimm;
   assign w_unused_zimm = ^r_zimm;
`endif

   // Decode the captured request: op class, old value, legality
   always_comb begin
      w_src       = r_src;
      w_is_csr_op = 1'b0;
      case (r_funct3)
         c_F3_CSRRW, c_F3_CSRRS, c_F3_CSRRC: w_is_csr_op = 1'b1;
`ifdef CSR_IMM_OPS_EN
         c_F3_CSRRWI, c_F3_CSRRSI, c_F3_CSRRCI: begin
            w_is_csr_op = 1'b1;
            w_src       = {{(XLEN-5){1'b0}}, r_zimm};
         end
`endif
         default: w_is_csr_op = 1'b0;
      endcase
      w_is_ecall = (r_funct3 == c_F3_PRIV) && (r_csr == c_IMM_ECALL);
      w_is_mret  = (r_funct3 == c_F3_PRIV) && (r_csr == c_IMM_MRET);

      w_old     = '0;
      w_addr_ok = 1'b1;
      case (r_csr)
         c_ADDR_MSTATUS:   w_old = dout_mstatus;
         c_ADDR_MTVEC:     w_old = dout_mtvec;
         c_ADDR_MEPC:      w_old = dout_mepc;
         c_ADDR_MCAUSE:    w_old = dout_mcause;
         c_ADDR_MVENDORID: w_old = dout_mvendorid;
         c_ADDR_MARCHID:   w_old = dout_marchid;
         default:          w_addr_ok = 1'b0;
      endcase

      // Set/clear with a zero source is a pure read; swap always writes
      w_do_write = w_is_csr_op && ((r_funct3[1:0] == 2'b01) || !r_src_zero);
      w_illegal  = !(w_is_ecall || w_is_mret || w_is_csr_op) ||
                   (w_is_csr_op && (!w_addr_ok || (w_do_write && csr_is_readonly(r_csr))));
   end

   csr_alu #(.XLEN(XLEN)) u_alu (
      .i_funct3 (r_funct3),
      .i_old    (w_old),
      .i_src    (w_src),
      .o_new    (w_alu_new)
   );

   // Write strobes and data before EXEC/reset gating
   always_comb begin
      w_wen_ms = 1'b0;
      w_wen_tv = 1'b0;
      w_wen_ep = 1'b0;
      w_wen_mc = 1'b0;
      w_din_ms = dout_mstatus;
      w_din_tv = w_alu_new;
      w_din_ep = w_alu_new;
      w_din_mc = w_alu_new;
      if (w_is_ecall) begin
         w_din_ms[c_MSTATUS_MPIE]                    = dout_mstatus[c_MSTATUS_MIE];
         w_din_ms[c_MSTATUS_MIE]                     = 1'b0;
         w_din_ms[c_MSTATUS_MPP_HI:c_MSTATUS_MPP_LO] = 2'b11;
         w_din_ep = r_pc;
         w_din_mc = ECALL_CAUSE;
         w_wen_ms = 1'b1;
         w_wen_ep = 1'b1;
         w_wen_mc = 1'b1;
      end else if (w_is_mret) begin
         w_din_ms[c_MSTATUS_MIE]                     = dout_mstatus[c_MSTATUS_MPIE];
         w_din_ms[c_MSTATUS_MPIE]                    = 1'b1;
         w_din_ms[c_MSTATUS_MPP_HI:c_MSTATUS_MPP_LO] = 2'b11;
         w_wen_ms = 1'b1;
      end else if (w_do_write && !w_illegal) begin
         w_din_ms = w_alu_new;
         case (r_csr)
            c_ADDR_MSTATUS: w_wen_ms = 1'b1;
            c_ADDR_MTVEC:   w_wen_tv = 1'b1;
            c_ADDR_MEPC:    w_wen_ep = 1'b1;
            c_ADDR_MCAUSE:  w_wen_mc = 1'b1;
            default:        w_wen_ms = 1'b0;
         endcase
      end
   end

   // Strobes only in EXEC; reset kills an in-flight write immediately
   assign w_exec      = (r_state == ST_EXEC) && !rst;
   assign wen_mstatus = w_exec && w_wen_ms;
   assign wen_mtvec   = w_exec && w_wen_tv;
   assign wen_mepc    = w_exec && w_wen_ep;
   assign wen_mcause  = w_exec && w_wen_mc;
   assign din_mstatus = w_exec ? w_din_ms : '0;
   assign din_mtvec   = w_exec ? w_din_tv : '0;
   assign din_mepc    = w_exec ? w_din_ep : '0;
   assign din_mcause  = w_exec ? w_din_mc : '0;

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.req_valid)  w_state_next = ST_EXEC;
         ST_EXEC:                     w_state_next = ST_RESP;
         ST_RESP: if (bus.resp_ready) w_state_next = ST_IDLE;
         default:                     w_state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Capture the request on acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         r_funct3   <= '0;
         r_csr      <= '0;
         r_src      <= '0;
         r_zimm     <= '0;
         r_src_zero <= 1'b0;
         r_pc       <= '0;
      end else if (r_state == ST_IDLE && bus.req_valid) begin
         r_funct3   <= bus.req_funct3;
         r_csr      <= bus.req_csr;
         r_src      <= bus.req_src;
         r_zimm     <= bus.req_zimm;
         r_src_zero <= bus.req_src_zero;
         r_pc       <= bus.req_pc;
      end
   end

   // Register the response at the end of EXEC; held through RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_rdata    <= '0;
         r_resp_npc      <= '0;
         r_resp_redirect <= 1'b0;
         r_resp_illegal  <= 1'b0;
      end else if (r_state == ST_EXEC) begin
         r_resp_rdata    <= (w_is_csr_op && !w_illegal) ? w_old : '0;
         r_resp_redirect <= w_is_ecall || w_is_mret;
         r_resp_npc      <= w_is_ecall ? (dout_mtvec & ~32'h3) :
                            w_is_mret  ? dout_mepc : '0;
         r_resp_illegal  <= w_illegal;
      end
   end

   assign bus.req_ready     = (r_state == ST_IDLE);
   assign bus.resp_valid    = (r_state == ST_RESP);
   assign bus.resp_rdata    = r_resp_rdata;
   assign bus.resp_npc      = r_resp_npc;
   assign bus.resp_redirect = r_resp_redirect;
   assign bus.resp_illegal  = r_resp_illegal;

endmodule

`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
// ============================================================================
// Module      : tb_csr_access_ctrl
// Description : Self-checking bench for csr_access_ctrl with a behavioural
//               CSR file. Vector table plus hand-written hold/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_access_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   csr_access_ctrl_if bus();

   logic [31:0] dout_mstatus, dout_mtvec, dout_mepc, dout_mcause, dout_mvendorid, dout_marchid;
   logic [31:0] din_mstatus, din_mtvec, din_mepc, din_mcause;
   logic        wen_mstatus, wen_mtvec, wen_mepc, wen_mcause;

   csr_access_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .dout_mstatus   (dout_mstatus),
      .dout_mtvec     (dout_mtvec),
      .dout_mepc      (dout_mepc),
      .dout_mcause    (dout_mcause),
      .dout_mvendorid (dout_mvendorid),
      .dout_marchid   (dout_marchid),
      .din_mstatus    (din_mstatus),
      .din_mtvec      (din_mtvec),
      .din_mepc       (din_mepc),
      .din_mcause     (din_mcause),
      .wen_mstatus    (wen_mstatus),
      .wen_mtvec      (wen_mtvec),
      .wen_mepc       (wen_mepc),
      .wen_mcause     (wen_mcause)
   );

   // Behavioural CSR file (not reset by the controller's rst)
   logic [31:0] m_ms = 32'h0000_1800;
   logic [31:0] m_tv = 32'h0;
   logic [31:0] m_ep = 32'h0;
   logic [31:0] m_mc = 32'h0;

   always @(posedge clk) begin
      if (wen_mstatus) m_ms <= din_mstatus;
      if (wen_mtvec)   m_tv <= din_mtvec;
      if (wen_mepc)    m_ep <= din_mepc;
      if (wen_mcause)  m_mc <= din_mcause;
   end

   assign dout_mstatus   = m_ms;
   assign dout_mtvec     = m_tv;
   assign dout_mepc      = m_ep;
   assign dout_mcause    = m_mc;
   assign dout_mvendorid = 32'h0;
   assign dout_marchid   = 32'h016F_E3BF;

   typedef struct {
      logic [2:0]  f3;
      logic [11:0] csr;
      logic [31:0] src;
      logic [4:0]  zimm;
      logic        sz;
      logic [31:0] pc;
      logic [31:0] e_rdata;
      logic        e_redir;
      logic [31:0] e_npc;
      logic        e_ill;
      logic [3:0]  e_wen;   // {mstatus, mtvec, mepc, mcause}
      logic [31:0] e_ms, e_tv, e_ep, e_mc;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", nm, idx, act, exp);
      end
   endtask

   task automatic drive_req(input vec_t v);
      bus.req_funct3   = v.f3;
      bus.req_csr      = v.csr;
      bus.req_src      = v.src;
      bus.req_zimm     = v.zimm;
      bus.req_src_zero = v.sz;
      bus.req_pc       = v.pc;
      bus.req_valid    = 1'b1;
   endtask

   function automatic logic [3:0] wen_now();
      return {wen_mstatus, wen_mtvec, wen_mepc, wen_mcause};
   endfunction

   task automatic run_op(input int idx, input vec_t v);
      int n;
      logic [3:0] wen_exec;
      @(negedge clk);
      drive_req(v);
      bus.resp_ready = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready", idx, {31'b0, bus.req_ready}, 32'd1);
      @(negedge clk);                       // EXEC cycle
      bus.req_valid = 1'b0;
      wen_exec = wen_now();
      chk("exec_resp_valid", idx, {31'b0, bus.resp_valid}, 32'd0);
      @(negedge clk);                       // RESP cycle
      chk("resp_valid", idx, {31'b0, bus.resp_valid}, 32'd1);
      chk("wen_exec", idx, {28'b0, wen_exec}, {28'b0, v.e_wen});
      chk("wen_resp", idx, {28'b0, wen_now()}, 32'd0);
      chk("rdata", idx, bus.resp_rdata, v.e_rdata);
      chk("redirect", idx, {31'b0, bus.resp_redirect}, {31'b0, v.e_redir});
      chk("npc", idx, bus.resp_npc, v.e_npc);
      chk("illegal", idx, {31'b0, bus.resp_illegal}, {31'b0, v.e_ill});
      @(negedge clk);                       // back in IDLE
      chk("resp_drop", idx, {31'b0, bus.resp_valid}, 32'd0);
      chk("mstatus", idx, m_ms, v.e_ms);
      chk("mtvec", idx, m_tv, v.e_tv);
      chk("mepc", idx, m_ep, v.e_ep);
      chk("mcause", idx, m_mc, v.e_mc);
   endtask

`ifdef CSR_IMM_OPS_EN
   localparam logic [31:0] EP14 = 32'h0000_0005;
`else
   localparam logic [31:0] EP14 = 32'h8000_0000;
`endif

   initial begin
      vec_t v;
      bus.req_valid = 1'b0; bus.req_funct3 = 3'b0; bus.req_csr = 12'h0; bus.req_src = 32'h0;
      bus.req_zimm = 5'd0; bus.req_src_zero = 1'b0; bus.req_pc = 32'h0; bus.resp_ready = 1'b0;

      // f3, csr, src, zimm, sz, pc | rdata, redir, npc, ill, wen, ms, tv, ep, mc
      vecs.push_back('{3'b001,12'h305,32'h80000100,5'd0,1'b0,32'h0, 32'h0,1'b0,32'h0,1'b0,4'b0100, 32'h1800,32'h80000100,32'h0,32'h0});
      vecs.push_back('{3'b010,12'h305,32'h0,5'd0,1'b1,32'h0, 32'h80000100,1'b0,32'h0,1'b0,4'b0000, 32'h1800,32'h80000100,32'h0,32'h0});
      vecs.push_back('{3'b010,12'h300,32'h8,5'd0,1'b0,32'h0, 32'h1800,1'b0,32'h0,1'b0,4'b1000, 32'h1808,32'h80000100,32'h0,32'h0});
      vecs.push_back('{3'b010,12'h300,32'h8,5'd0,1'b1,32'h0, 32'h1808,1'b0,32'h0,1'b0,4'b0000, 32'h1808,32'h80000100,32'h0,32'h0});
      vecs.push_back('{3'b000,12'h000,32'h0,5'd0,1'b1,32'h80000010, 32'h0,1'b1,32'h80000100,1'b0,4'b1011, 32'h1880,32'h80000100,32'h80000010,32'hB});
      vecs.push_back('{3'b000,12'h302,32'h0,5'd0,1'b1,32'h80000020, 32'h0,1'b1,32'h80000010,1'b0,4'b1000, 32'h1888,32'h80000100,32'h80000010,32'hB});
      vecs.push_back('{3'b001,12'hF11,32'h1234,5'd0,1'b0,32'h0, 32'h0,1'b0,32'h0,1'b1,4'b0000, 32'h1888,32'h80000100,32'h80000010,32'hB});
      vecs.push_back('{3'b010,12'hF12,32'h0,5'd0,1'b1,32'h0, 32'h016FE3BF,1'b0,32'h0,1'b0,4'b0000, 32'h1888,32'h80000100,32'h80000010,32'hB});
      vecs.push_back('{3'b010,12'h7C0,32'h0,5'd0,1'b1,32'h0, 32'h0,1'b0,32'h0,1'b1,4'b0000, 32'h1888,32'h80000100,32'h80000010,32'hB});
      vecs.push_back('{3'b011,12'h341,32'h10,5'd0,1'b0,32'h0, 32'h80000010,1'b0,32'h0,1'b0,4'b0010, 32'h1888,32'h80000100,32'h80000000,32'hB});
      vecs.push_back('{3'b011,12'h342,32'hFF,5'd0,1'b1,32'h0, 32'hB,1'b0,32'h0,1'b0,4'b0000, 32'h1888,32'h80000100,32'h80000000,32'hB});
      vecs.push_back('{3'b100,12'h300,32'h1,5'd0,1'b0,32'h0, 32'h0,1'b0,32'h0,1'b1,4'b0000, 32'h1888,32'h80000100,32'h80000000,32'hB});
      vecs.push_back('{3'b000,12'h105,32'h0,5'd0,1'b1,32'h0, 32'h0,1'b0,32'h0,1'b1,4'b0000, 32'h1888,32'h80000100,32'h80000000,32'hB});
      vecs.push_back('{3'b001,12'h342,32'h7,5'd0,1'b0,32'h0, 32'hB,1'b0,32'h0,1'b0,4'b0001, 32'h1888,32'h80000100,32'h80000000,32'h7});
`ifdef CSR_IMM_OPS_EN
      vecs.push_back('{3'b101,12'h341,32'hDEADBEEF,5'd5,1'b0,32'h0, 32'h80000000,1'b0,32'h0,1'b0,4'b0010, 32'h1888,32'h80000100,32'h5,32'h7});
`else
      vecs.push_back('{3'b101,12'h341,32'hDEADBEEF,5'd5,1'b0,32'h0, 32'h0,1'b0,32'h0,1'b1,4'b0000, 32'h1888,32'h80000100,32'h80000000,32'h7});
`endif
      vecs.push_back('{3'b001,12'h305,32'h80000203,5'd0,1'b0,32'h0, 32'h80000100,1'b0,32'h0,1'b0,4'b0100, 32'h1888,32'h80000203,EP14,32'h7});
      vecs.push_back('{3'b000,12'h000,32'h0,5'd0,1'b1,32'h80000044, 32'h0,1'b1,32'h80000200,1'b0,4'b1011, 32'h1880,32'h80000203,32'h80000044,32'hB});
      vecs.push_back('{3'b010,12'hF11,32'h1,5'd0,1'b0,32'h0, 32'h0,1'b0,32'h0,1'b1,4'b0000, 32'h1880,32'h80000203,32'h80000044,32'hB});

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_req_ready", 0, {31'b0, bus.req_ready}, 32'd1);
      chk("rst_resp_valid", 0, {31'b0, bus.resp_valid}, 32'd0);
      chk("rst_rdata", 0, bus.resp_rdata, 32'h0);
      chk("rst_npc", 0, bus.resp_npc, 32'h0);
      chk("rst_flags", 0, {30'b0, bus.resp_redirect, bus.resp_illegal}, 32'd0);
      chk("rst_wen", 0, {28'b0, wen_now()}, 32'd0);
      chk("rst_din", 0, din_mstatus | din_mtvec | din_mepc | din_mcause, 32'h0);

      foreach (vecs[i]) run_op(i, vecs[i]);

      // MRET with the response back-pressured for 5 cycles
      v = '{3'b000,12'h302,32'h0,5'd0,1'b1,32'h0, 32'h0,1'b1,32'h80000044,1'b0,4'b1000, 32'h1888,32'h80000203,32'h80000044,32'hB};
      @(negedge clk);
      drive_req(v);
      bus.resp_ready = 1'b0;
      @(negedge clk);                       // EXEC; offer another request that must be ignored
      bus.req_funct3 = 3'b001; bus.req_csr = 12'h305; bus.req_src = 32'h0; bus.req_src_zero = 1'b0;
      chk("hold_wen_exec", 0, {28'b0, wen_now()}, 32'b1000);
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         chk("hold_valid", k, {31'b0, bus.resp_valid}, 32'd1);
         chk("hold_req_ready", k, {31'b0, bus.req_ready}, 32'd0);
         chk("hold_npc", k, bus.resp_npc, 32'h80000044);
         chk("hold_rdata", k, bus.resp_rdata, 32'h0);
         chk("hold_flags", k, {30'b0, bus.resp_redirect, bus.resp_illegal}, 32'b10);
         chk("hold_wen", k, {28'b0, wen_now()}, 32'd0);
         if (k < 5) @(negedge clk);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("hold_release", 0, {31'b0, bus.resp_valid}, 32'd0);
      chk("hold_idle", 0, {31'b0, bus.req_ready}, 32'd1);
      chk("hold_mstatus", 0, m_ms, 32'h1888);
      chk("hold_mtvec", 0, m_tv, 32'h80000203);

      // Reset asserted during EXEC of a CSRRW suppresses the write
      v = '{3'b001,12'h305,32'h11111111,5'd0,1'b0,32'h0, 32'h0,1'b0,32'h0,1'b0,4'b0100, 32'h1888,32'h80000203,32'h80000044,32'hB};
      @(negedge clk);
      drive_req(v);
      @(negedge clk);                       // EXEC
      bus.req_valid = 1'b0;
      chk("rstx_pre_wen", 0, {31'b0, wen_mtvec}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstx_wen", 0, {28'b0, wen_now()}, 32'd0);
      chk("rstx_din", 0, din_mtvec, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstx_resp_valid", 0, {31'b0, bus.resp_valid}, 32'd0);
      chk("rstx_req_ready", 0, {31'b0, bus.req_ready}, 32'd1);
      chk("rstx_mtvec", 0, m_tv, 32'h80000203);
      @(negedge clk);
      chk("rstx_no_resp", 0, {31'b0, bus.resp_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog so the bench always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
